seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, clocked successor to the CPU's combinational ALU.
- Keeps the same 4-bit op encoding and flag semantics; adds a WIDTH parameter and a valid/ready input handshake.
- Logic, add/sub and shift ops complete in one cycle; multiply, divide and modulo run as iterative multi-cycle operations.
- Sits between the register-read stage and writeback; the control unit stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4); shift amount uses b[$clog2(WIDTH)-1:0] plus an out-of-range check on the upper bits.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- carry_in  in  1  carry for ADD/SUB
- alu_op  in  4  operation select
- out_valid  out  1  one-cycle pulse: result and flags are new this cycle
- out  out  WIDTH  result, held until the next result
- set_flags  out  1  flags must be written (0 for ops 0000/0001)
- carry_out  out  1  carry (ADD/SUB only, else 0)
- zero_out  out  1  out == 0
- neg_out  out  1  out[WIDTH-1]
- div_by_zero  out  1  last divide/mod op had b == 0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out=0, carry_out=0, div_by_zero=0, set_flags=0.
  - zero_out therefore reads 1 and neg_out reads 0.
- States: IDLE, MUL, DIV, DONE.
- Accept: a request is taken when in_valid & in_ready on a clk edge. a, b, carry_in and alu_op are captured at that edge and are don't-care afterwards.
- Single-cycle ops (0000-1001, 1110, 1111):
  - Result is registered at the accept edge; out_valid=1 in the next cycle (latency 1).
  - in_ready stays 1, so back-to-back issue is allowed at one op per cycle.
- Op semantics, all modulo 2^WIDTH:
  - 0000 = a; 0001 = b; 0010 = ~a; 0011 = a with MSB inverted.
  - 0100 = a&b; 0101 = a|b; 0110 = a^b; 0111 = a&~b.
  - 1000: a+b+cin. carry_out = bit WIDTH of the (WIDTH+1)-bit zero-extended sum.
  - 1001: a-b-1+cin. carry_out = bit WIDTH of the same (WIDTH+1)-bit computation, so 1 means borrow.
  - 1110: a<<b. 1111: logical a>>b. If b ≥ WIDTH, result = 0.
- Multiply (1010):
  - IDLE→MUL; shift-add, one bit per cycle, for WIDTH cycles, then →DONE.
  - Result = low WIDTH bits of the product.
- Divide/modulo (1011 unsigned a%b, 1100 signed a/b, 1101 unsigned a/b):
  - IDLE→DIV; radix-2 restoring, one bit per cycle, for WIDTH cycles, then →DONE.
  - Signed: divide the magnitudes, truncate toward zero, quotient negated when a and b signs differ.
  - Signed MIN / -1 = MIN (wraps, no flag).
- Multi-cycle timing:
  - in_ready=0 from the cycle after accept until DONE.
  - In DONE: out_valid=1, in_ready=1. A new request may be accepted in DONE, then →IDLE or straight into MUL/DIV.
  - Accept-edge to out_valid latency is exactly WIDTH+1 cycles, regardless of operand values.
- b == 0 on 1011/1100/1101:
  - Full latency is still used.
  - Quotient = all ones; remainder (1011) = a; div_by_zero=1.
  - Any other completed op clears div_by_zero.
- set_flags is 0 for 0000/0001 and 1 otherwise; it is qualified by out_valid.
- in_valid while in_ready=0 is ignored; the requester must hold the request.
- Reset asserted mid-MUL/DIV aborts the op: outputs return to reset values and no out_valid is produced.

Decomposition:
- Package alu_pkg:
  - localparams for the 16 op encodings (OP_MOVA … OP_SHR);
  - state encoding (IDLE/MUL/DIV/DONE);
  - helper function is_multicycle(op).
- Sub-module seq_divider (WIDTH param): unsigned restoring divider.
  - Interface: start/a/b in; quotient/remainder/done out.
  - seq_alu handles sign fix-up around it and the b==0 override.
- Multiplier stays inline (shift register plus accumulator).

Test Plan (WIDTH=32):
- 1000, a=FFFFFFFF, b=1, cin=0 → out_valid next cycle, out=0, carry=1, zero=1, set_flags=1.
- Back-to-back 0100 (a=F0F0F0F0, b=FF00FF00), then 0001 (b=12345678) → out=F000F000, then 12345678; set_flags=1 then 0; out_valid on 2 consecutive cycles.
- 1010, a=0001_0000, b=0001_0001 → in_ready low 32 cycles, out_valid exactly 33 cycles after accept, out=00010000.
- 1100, a=FFFFFFF9 (-7), b=2 → out=FFFFFFFD (-3), neg=1; 1100, a=80000000, b=FFFFFFFF → 80000000.
- 1101, b=0, a=5 → out=FFFFFFFF, div_by_zero=1 at 33 cycles; then 1011, b=0 → out=5; then 0000 clears div_by_zero.
- Reset pulsed 10 cycles into a 1101 → no out_valid, out=0, in_ready=1 after release; a subsequent 1001 (a=3, b=5, cin=1) → out=FFFFFFFE, carry=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, controller
// states and the single/multi-cycle classification of ops.
package alu_pkg;

    localparam logic [3:0] OP_MOVA    = 4'b0000;
    localparam logic [3:0] OP_MOVB    = 4'b0001;
    localparam logic [3:0] OP_NOTA    = 4'b0010;
    localparam logic [3:0] OP_FLIPMSB = 4'b0011;
    localparam logic [3:0] OP_AND     = 4'b0100;
    localparam logic [3:0] OP_OR      = 4'b0101;
    localparam logic [3:0] OP_XOR     = 4'b0110;
    localparam logic [3:0] OP_ANDN    = 4'b0111;
    localparam logic [3:0] OP_ADD     = 4'b1000;
    localparam logic [3:0] OP_SUB     = 4'b1001;
    localparam logic [3:0] OP_MUL     = 4'b1010;
    localparam logic [3:0] OP_UMOD    = 4'b1011;
    localparam logic [3:0] OP_SDIV    = 4'b1100;
    localparam logic [3:0] OP_UDIV    = 4'b1101;
    localparam logic [3:0] OP_SHL     = 4'b1110;
    localparam logic [3:0] OP_SHR     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Ops that occupy the iterative multiplier or divider.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UMOD) || (op == OP_SDIV) || (op == OP_UDIV);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider. The first quotient bit is produced
// on the start edge itself, so all WIDTH bits are ready WIDTH-1 edges
// later and done pulses for one cycle with quotient/remainder valid.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_rem;
    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_dvs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // One restoring step, fed from the operands on start, else from state.
    always_comb begin
        src_rem   = start ? '0 : rem_q;
        src_quo   = start ? a  : quo_q;
        src_dvs   = start ? b  : dvs_q;
        rem_shift = {src_rem, src_quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, src_dvs};
        fits      = ~trial[WIDTH];
        step_rem  = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        step_quo  = {src_quo[WIDTH-2:0], fits};
    end

    // Iteration control: load on start, then step until the last bit.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            dvs_d  = b;
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Control state, cleared by reset so an aborted division never completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Datapath registers; only meaningful while busy, so no reset needed.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with a valid/ready request port. Logic, add/sub and shift
// ops register their result on the accept edge; multiply (inline
// shift-add) and divide/modulo (seq_divider) take WIDTH+1 cycles.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             set_flags,
    output logic             carry_out,
    output logic             zero_out,
    output logic             neg_out,
    output logic             div_by_zero
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    // Single-cycle ops; returns {carry, result}. Logic ops leave the carry at 0.
    function automatic logic [WIDTH:0] single_cycle_op(input logic [3:0] op,
                                                       input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y,
                                                       input logic cin);
        logic [WIDTH:0] cin_ext;
        logic           shift_oor;
        logic [WIDTH:0] r;
        cin_ext   = {{WIDTH{1'b0}}, cin};
        shift_oor = (y >= WIDTH_V);
        case (op)
            OP_MOVA:    r = {1'b0, x};
            OP_MOVB:    r = {1'b0, y};
            OP_NOTA:    r = {1'b0, ~x};
            OP_FLIPMSB: r = {1'b0, x ^ MSB_MASK};
            OP_AND:     r = {1'b0, x & y};
            OP_OR:      r = {1'b0, x | y};
            OP_XOR:     r = {1'b0, x ^ y};
            OP_ANDN:    r = {1'b0, x & ~y};
            // Bit WIDTH is the carry out of the zero-extended sum.
            OP_ADD:     r = {1'b0, x} + {1'b0, y} + cin_ext;
            // Same extended arithmetic; bit WIDTH set means a borrow occurred.
            OP_SUB:     r = {1'b0, x} - {1'b0, y} - {1'b0, ONE} + cin_ext;
            OP_SHL:     r = {1'b0, shift_oor ? ZERO : (x << y[SHW-1:0])};
            OP_SHR:     r = {1'b0, shift_oor ? ZERO : (x >> y[SHW-1:0])};
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Magnitude of a two's-complement value; the most negative value maps
    // to itself, which reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             set_flags_q, set_flags_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             qneg_q, qneg_d;
    logic             bzero_q, bzero_d;

    logic             accept;
    logic             div_start;
    logic             is_sdiv_in;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_done;
    logic [WIDTH:0]   single_res;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] div_result;

    assign in_ready = (state_q != ST_MUL) && (state_q != ST_DIV);
    assign accept   = in_valid && in_ready;

    // Divider operands: signed divide works on magnitudes, sign fixed afterwards.
    always_comb begin
        is_sdiv_in = (alu_op == OP_SDIV);
        div_start  = accept && is_multicycle(alu_op) && (alu_op != OP_MUL);
        div_a      = is_sdiv_in ? magnitude(a) : a;
        div_b      = is_sdiv_in ? magnitude(b) : b;
    end

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .a         (div_a),
        .b         (div_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Datapath helpers: single-cycle result, one multiply step, divide fix-up.
    always_comb begin
        single_res = single_cycle_op(alu_op, a, b, carry_in);
        acc_step   = acc_q + (mplier_q[0] ? mcand_q : ZERO);
        // A zero divisor still runs the full latency; its remainder is
        // naturally a, and the quotient is forced to all ones.
        if (bzero_q) begin
            div_result = (op_q == OP_UMOD) ? div_rem : ONES;
        end else if (op_q == OP_UMOD) begin
            div_result = div_rem;
        end else if (op_q == OP_SDIV && qneg_q) begin
            div_result = WIDTH'(-div_quo);
        end else begin
            div_result = div_quo;
        end
    end

    // Controller: accept in IDLE/DONE, iterate in MUL/DIV, publish results.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        out_d       = out_q;
        carry_d     = carry_q;
        set_flags_d = set_flags_q;
        dbz_d       = dbz_q;
        out_valid_d = 1'b0;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        qneg_d      = qneg_q;
        bzero_d     = bzero_q;
        case (state_q)
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d     = ST_DONE;
                    out_d       = acc_step;
                    carry_d     = 1'b0;
                    set_flags_d = 1'b1;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d     = ST_DONE;
                    out_d       = div_result;
                    carry_d     = 1'b0;
                    set_flags_d = 1'b1;
                    dbz_d       = bzero_q;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (is_multicycle(alu_op)) begin
                        state_d  = (alu_op == OP_MUL) ? ST_MUL : ST_DIV;
                        op_d     = alu_op;
                        cnt_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        qneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        bzero_d  = (b == ZERO);
                    end else begin
                        out_d       = single_res[WIDTH-1:0];
                        carry_d     = single_res[WIDTH];
                        set_flags_d = (alu_op != OP_MOVA) && (alu_op != OP_MOVB);
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control and visible result registers; reset aborts any running op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MOVA;
            out_q       <= '0;
            carry_q     <= 1'b0;
            set_flags_q <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
            set_flags_q <= set_flags_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Multiplier and divide fix-up operands; loaded on accept before use.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        qneg_q   <= qneg_d;
        bzero_q  <= bzero_d;
    end

    assign out_valid   = out_valid_q;
    assign out         = out_q;
    assign set_flags   = set_flags_q;
    assign carry_out   = carry_q;
    assign zero_out    = (out_q == ZERO);
    assign neg_out     = out_q[WIDTH-1];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): directed vectors with literal
// expectations plus randomized ops checked against an arithmetic model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic        carry;
        logic        sf;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic [31:0] out;
    logic        set_flags;
    logic        carry_out;
    logic        zero_out;
    logic        neg_out;
    logic        div_by_zero;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .alu_op      (alu_op),
        .out_valid   (out_valid),
        .out         (out),
        .set_flags   (set_flags),
        .carry_out   (carry_out),
        .zero_out    (zero_out),
        .neg_out     (neg_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic multi(input logic [3:0] op);
        return op >= 4'd10 && op <= 4'd13;
    endfunction

    // Reference model straight from the op definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                   input logic [31:0] y, input logic c);
        exp_t e;
        logic [32:0] s;
        logic [63:0] p;
        longint sx, sy, qq;
        e.res = 32'd0; e.carry = 1'b0; e.dbz = 1'b0; e.acc = 0;
        e.sf  = (op > 4'd1);
        e.lat = multi(op) ? W + 1 : 1;
        case (op)
            4'd0:  e.res = x;
            4'd1:  e.res = y;
            4'd2:  e.res = ~x;
            4'd3:  e.res = x ^ 32'h8000_0000;
            4'd4:  e.res = x & y;
            4'd5:  e.res = x | y;
            4'd6:  e.res = x ^ y;
            4'd7:  e.res = x & ~y;
            4'd8:  begin s = {1'b0, x} + {1'b0, y} + 33'(c); e.res = s[31:0]; e.carry = s[32]; end
            4'd9:  begin s = {1'b0, x} - {1'b0, y} - 33'd1 + 33'(c); e.res = s[31:0]; e.carry = s[32]; end
            4'd10: begin p = 64'(x) * 64'(y); e.res = p[31:0]; end
            4'd11: begin e.dbz = (y == 0); e.res = (y == 0) ? x : x % y; end
            4'd12: begin
                e.dbz = (y == 0);
                if (y == 0) e.res = 32'hFFFF_FFFF;
                else begin
                    sx = longint'($signed(x)); sy = longint'($signed(y));
                    qq = sx / sy;
                    e.res = 32'(qq);
                end
            end
            4'd13: begin e.dbz = (y == 0); e.res = (y == 0) ? 32'hFFFF_FFFF : x / y; end
            4'd14: e.res = (y >= 32) ? 32'd0 : x << y;
            default: e.res = (y >= 32) ? 32'd0 : x >> y;
        endcase
        return e;
    endfunction

    function automatic exp_t lit(input logic [3:0] op, input logic [31:0] r,
                                 input logic cy, input logic d);
        exp_t e;
        e.res = r; e.carry = cy; e.dbz = d; e.sf = (op > 4'd1);
        e.lat = multi(op) ? W + 1 : 1; e.acc = 0;
        return e;
    endfunction

    // Called at a negedge; holds the request until accepted, returns at the
    // negedge after the accept edge with in_valid still high.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input exp_t e);
        int guard = 0;
        in_valid = 1'b1; alu_op = op; a = x; b = y; carry_in = c;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom); carry_in = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_set_flags", 32'(set_flags), 32'd0);
        chk("rst_zero", 32'(zero_out), 32'd1);
        chk("rst_neg", 32'(neg_out), 32'd0);
    endtask

    // Monitor: every out_valid cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 required=0 out=%h (cycle %0d)", out, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("out", out, mon_e.res);
                chk("carry_out", 32'(carry_out), 32'(mon_e.carry));
                chk("set_flags", 32'(set_flags), 32'(mon_e.sf));
                chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                chk("zero_out", 32'(zero_out), 32'(mon_e.res == 32'd0));
                chk("neg_out", 32'(neg_out), 32'(mon_e.res[31]));
                chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] x, y;
        logic        c;
        int          n;

        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; alu_op = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;
        @(negedge clk);

        // Add with carry out wrapping to zero.
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, lit(OP_ADD, 32'h0, 1'b1, 1'b0));
        idle(); drain();

        // Back-to-back single-cycle ops.
        issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lit(OP_AND, 32'hF000_F000, 1'b0, 1'b0));
        issue(OP_MOVB, 32'h0, 32'h1234_5678, 1'b0, lit(OP_MOVB, 32'h1234_5678, 1'b0, 1'b0));
        idle(); drain();

        // Multiply: busy for WIDTH cycles after accept.
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0001, 1'b0, lit(OP_MUL, 32'h0001_0000, 1'b0, 1'b0));
        idle();
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mul_ready_low_cycles", 32'(n), 32'd32);
        drain();

        // Signed divide, including MIN / -1.
        issue(OP_SDIV, 32'hFFFF_FFF9, 32'h2, 1'b0, lit(OP_SDIV, 32'hFFFF_FFFD, 1'b0, 1'b0));
        issue(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lit(OP_SDIV, 32'h8000_0000, 1'b0, 1'b0));
        idle(); drain();

        // Divide by zero sets the flag; any later non-divide clears it.
        issue(OP_UDIV, 32'h5, 32'h0, 1'b0, lit(OP_UDIV, 32'hFFFF_FFFF, 1'b0, 1'b1));
        issue(OP_UMOD, 32'h5, 32'h0, 1'b0, lit(OP_UMOD, 32'h5, 1'b0, 1'b1));
        issue(OP_MOVA, 32'h5, 32'h0, 1'b0, lit(OP_MOVA, 32'h5, 1'b0, 1'b0));
        idle(); drain();

        // Reset mid-divide: no result, then normal operation resumes.
        issue(OP_UDIV, 32'd100, 32'd7, 1'b0, lit(OP_UDIV, 32'd14, 1'b0, 1'b0));
        idle();
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check_reset_state();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out", out, 32'd0);
        issue(OP_SUB, 32'd3, 32'd5, 1'b1, lit(OP_SUB, 32'hFFFF_FFFE, 1'b1, 1'b0));
        idle(); drain();

        // Randomized ops against the model, with occasional idle gaps.
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: x = 32'h0; 1: x = 32'hFFFF_FFFF; 2: x = 32'h8000_0000; 3: x = 32'h1;
                default: x = $urandom;
            endcase
            if (op >= 4'd14) begin
                y = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            end else begin
                case ($urandom_range(0, 6))
                    0: y = 32'h0; 1: y = 32'hFFFF_FFFF; 2: y = 32'h8000_0000; 3: y = 32'($urandom_range(1, 9));
                    default: y = $urandom;
                endcase
            end
            c = 1'($urandom);
            issue(op, x, y, c, model(op, x, y, c));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(negedge clk);
            end
        end
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
